// File: rtl/gcm_pkg.sv
// Shared definitions for the GCM packet merge/realign stages: word geometry,
// payload window bounds and the per-packet word phase.
package gcm_pkg;

  localparam int unsigned GCM_W_WORD = 289;
  localparam int unsigned GCM_W_BLK  = 128;
  localparam int unsigned GCM_W_RES  = 16;

  // Residue sits at the top of the word; the 112-bit block body sits below it.
  localparam int unsigned GCM_RES_HI = 288;
  localparam int unsigned GCM_RES_LO = 273;
  localparam int unsigned GCM_WIN_HI = 272;
  localparam int unsigned GCM_WIN_LO = 161;

  localparam logic [4:0] GCM_BYTES_FULL = 5'd16;
  localparam logic [4:0] GCM_BYTES_RES  = 5'd2;

  typedef enum logic [1:0] {
    FIRST,
    SECOND,
    INNER,
    FLUSH
  } gcm_phase_e;

endpackage

// File: rtl/payload_realigner_blk_out_reg.sv
// Single-entry valid/ready output register; a pop and a load in the same
// cycle keep the entry occupied with the new block.
module blk_out_reg #(
  parameter int unsigned W_BLK = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [W_BLK-1:0] i_data,
  input  logic             i_last,
  input  logic [4:0]       i_bytes,
  input  logic             i_ready,
  output logic             o_free,
  output logic             o_valid,
  output logic [W_BLK-1:0] o_data,
  output logic             o_last,
  output logic [4:0]       o_bytes
);

  logic             r_valid;
  logic [W_BLK-1:0] r_data;
  logic             r_last;
  logic [4:0]       r_bytes;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_bytes <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
      r_bytes <= i_bytes;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_free  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;
  assign o_bytes = r_bytes;

endmodule

// File: rtl/payload_realigner.sv
// Splits the 289-bit packet word stream into header words and 128-bit-aligned
// payload blocks for the GCM decrypt/authenticate core.
module payload_realigner #(
  parameter int unsigned W_WORD = 289,
  parameter int unsigned W_BLK  = 128,
  parameter int unsigned W_RES  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W_WORD-1:0] i_text,
  input  logic              i_valid,
  input  logic              i_last,
  output logic              o_in_ready,
  output logic [W_WORD-1:0] o_hdr,
  output logic              o_hdr_valid,
  output logic [W_BLK-1:0]  o_block,
  output logic              o_block_valid,
  output logic              o_block_last,
  output logic [4:0]        o_block_bytes,
  input  logic              i_block_ready
);
  import gcm_pkg::*;

  gcm_phase_e        r_state;
  gcm_phase_e        w_next_state;
  logic [W_RES-1:0]  r_res;
  logic [W_WORD-1:0] r_hdr;
  logic              r_hdr_valid;

  logic              w_free;
  logic              w_accept;
  logic              w_load;
  logic [W_BLK-1:0]  w_blk_data;
  logic              w_blk_last;
  logic [4:0]        w_blk_bytes;

  assign o_in_ready = (r_state != FLUSH) && w_free;
  assign w_accept   = i_valid && o_in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= FIRST;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_blk_data   = '0;
    w_blk_last   = 1'b0;
    w_blk_bytes  = '0;
    case (r_state)
      FIRST: begin
        if (w_accept) begin
          w_next_state = i_last ? FIRST : SECOND;
        end
      end
      SECOND: begin
        if (w_accept) begin
          w_next_state = i_last ? FLUSH : INNER;
        end
      end
      INNER: begin
        if (w_accept) begin
          w_load       = 1'b1;
          w_blk_data   = {i_text[GCM_WIN_HI:GCM_WIN_LO], r_res};
          w_blk_bytes  = GCM_BYTES_FULL;
          w_next_state = i_last ? FLUSH : INNER;
        end
      end
      FLUSH: begin
        if (w_free) begin
          w_load       = 1'b1;
          w_blk_data   = {{(W_BLK-W_RES){1'b0}}, r_res};
          w_blk_last   = 1'b1;
          w_blk_bytes  = GCM_BYTES_RES;
          w_next_state = FIRST;
        end
      end
      default: w_next_state = FIRST;
    endcase
  end

  // Residue tracks every accepted word; only SECOND/INNER loads are ever consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res       <= '0;
      r_hdr       <= '0;
      r_hdr_valid <= 1'b0;
    end else begin
      r_hdr_valid <= 1'b0;
      if (w_accept) begin
        r_res <= i_text[GCM_RES_HI:GCM_RES_LO];
        if (r_state == FIRST) begin
          r_hdr       <= i_text;
          r_hdr_valid <= 1'b1;
        end else if (r_state == SECOND) begin
          r_hdr       <= {{W_RES{1'b0}}, i_text[GCM_WIN_HI:0]};
          r_hdr_valid <= 1'b1;
        end
      end
    end
  end

  assign o_hdr       = r_hdr;
  assign o_hdr_valid = r_hdr_valid;

  blk_out_reg #(
    .W_BLK(W_BLK)
  ) u_blk_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_data  (w_blk_data),
    .i_last  (w_blk_last),
    .i_bytes (w_blk_bytes),
    .i_ready (i_block_ready),
    .o_free  (w_free),
    .o_valid (o_block_valid),
    .o_data  (o_block),
    .o_last  (o_block_last),
    .o_bytes (o_block_bytes)
  );

endmodule

// File: tb/tb_payload_realigner.sv
// Directed bench for payload_realigner: a reference model fills header and
// block queues as words are accepted; a negedge monitor checks DUT output.
module tb_payload_realigner;

  typedef struct {
    logic [127:0] d;
    logic         last;
    logic [4:0]   bytes;
  } blk_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [288:0] i_text;
  logic         i_valid;
  logic         i_last;
  logic         o_in_ready;
  logic [288:0] o_hdr;
  logic         o_hdr_valid;
  logic [127:0] o_block;
  logic         o_block_valid;
  logic         o_block_last;
  logic [4:0]   o_block_bytes;
  logic         i_block_ready;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [288:0] q_hdr[$];
  blk_t         q_blk[$];
  int           pkt_idx = 0;
  logic [15:0]  m_res   = '0;

  always #5 clk = ~clk;

  payload_realigner #(
    .W_WORD(289),
    .W_BLK (128),
    .W_RES (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_text        (i_text),
    .i_valid       (i_valid),
    .i_last        (i_last),
    .o_in_ready    (o_in_ready),
    .o_hdr         (o_hdr),
    .o_hdr_valid   (o_hdr_valid),
    .o_block       (o_block),
    .o_block_valid (o_block_valid),
    .o_block_last  (o_block_last),
    .o_block_bytes (o_block_bytes),
    .i_block_ready (i_block_ready)
  );

  function automatic logic [288:0] mkw(input logic [15:0] res, input logic [111:0] mid);
    logic [160:0] lo;
    lo = '0;
    for (int i = 0; i < 6; i++) lo = {lo[128:0], $urandom()};
    return {res, mid, lo};
  endfunction

  function automatic logic [111:0] rmid();
    logic [111:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m = {m[79:0], $urandom()};
    return m;
  endfunction

  // Reference model: what each accepted word must produce downstream.
  task automatic model_accept(input logic [288:0] w, input logic last);
    blk_t b;
    pkt_idx++;
    if (pkt_idx == 1) begin
      q_hdr.push_back(w);
    end else if (pkt_idx == 2) begin
      q_hdr.push_back({16'h0000, w[272:0]});
    end else begin
      b.d = {w[272:161], m_res}; b.last = 1'b0; b.bytes = 5'd16;
      q_blk.push_back(b);
    end
    m_res = w[288:273];
    if (last) begin
      if (pkt_idx >= 2) begin
        b.d = {112'h0, m_res}; b.last = 1'b1; b.bytes = 5'd2;
        q_blk.push_back(b);
      end
      pkt_idx = 0;
    end
  endtask

  // Presents a word until accepted; waited = cycles with o_in_ready low.
  task automatic send_word(input logic [288:0] w, input logic last, output int waited);
    logic acc;
    acc    = 1'b0;
    waited = 0;
    i_text = w; i_valid = 1'b1; i_last = last;
    while (!acc && waited < 50) begin
      @(negedge clk);
      acc = o_in_ready;
      @(posedge clk);
      #1;
      if (!acc) waited++;
    end
    i_valid = 1'b0; i_last = 1'b0; i_text = '1;
    n_asserts++;
    assert (acc === 1'b1) else begin
      n_fail++;
      $error("FAIL accept_timeout obs=%b exp=1", acc);
    end
    if (acc) model_accept(w, last);
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (o_hdr_valid === 1'b1) begin
        n_asserts++;
        assert (q_hdr.size() != 0) else begin
          n_fail++;
          $error("FAIL hdr_unexpected obs=%h exp=none", o_hdr);
        end
        if (q_hdr.size() != 0) begin
          n_asserts++;
          assert (o_hdr === q_hdr[0]) else begin
            n_fail++;
            $error("FAIL hdr obs=%h exp=%h", o_hdr, q_hdr[0]);
          end
          void'(q_hdr.pop_front());
        end
      end
      if (o_block_valid === 1'b1) begin
        n_asserts++;
        assert (q_blk.size() != 0) else begin
          n_fail++;
          $error("FAIL blk_unexpected obs=%h exp=none", o_block);
        end
        if (q_blk.size() != 0) begin
          n_asserts++;
          assert ({o_block, o_block_last, o_block_bytes} ===
                  {q_blk[0].d, q_blk[0].last, q_blk[0].bytes}) else begin
            n_fail++;
            $error("FAIL blk obs=%h/%b/%0d exp=%h/%b/%0d", o_block, o_block_last,
                   o_block_bytes, q_blk[0].d, q_blk[0].last, q_blk[0].bytes);
          end
          if (i_block_ready === 1'b1) void'(q_blk.pop_front());
        end
      end
    end
  end

  initial begin
    int wt;
    int wt_bp;
    rst_n = 1'b0; i_valid = 1'b0; i_last = 1'b0; i_text = '0; i_block_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_int("rst_hdr_valid", int'(o_hdr_valid), 0);
    n_asserts++;
    assert ({o_hdr, o_block, o_block_valid, o_block_last, o_block_bytes} === '0) else begin
      n_fail++;
      $error("FAIL rst_outputs obs=%h/%h/%b/%b/%0d exp=0", o_hdr, o_block,
             o_block_valid, o_block_last, o_block_bytes);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // i_last without i_valid does nothing
    i_last = 1'b1;
    repeat (2) @(posedge clk);
    #1; i_last = 1'b0;
    @(negedge clk);
    check_int("last_no_valid_hdr", int'(o_hdr_valid), 0);
    check_int("last_no_valid_blk", int'(o_block_valid), 0);
    @(posedge clk); #1;

    // 2-word packet
    send_word(mkw($urandom(), rmid()), 1'b0, wt);
    send_word(mkw(16'hBEEF, rmid()), 1'b1, wt);

    // 1-word packet; FLUSH gap of one cycle precedes it
    send_word(mkw($urandom(), rmid()), 1'b1, wt);
    check_int("flush_gap_2w", wt, 1);

    // 4-word packet; after a 1-word packet the next word is accepted at once
    send_word(mkw($urandom(), rmid()), 1'b0, wt);
    check_int("no_gap_after_1w", wt, 0);
    send_word(mkw(16'h1111, rmid()), 1'b0, wt);
    send_word(mkw(16'h2222, {28{4'hA}}), 1'b0, wt);
    send_word(mkw(16'h3333, {28{4'hB}}), 1'b1, wt);

    // Back-to-back 3-word packet
    send_word(mkw($urandom(), rmid()), 1'b0, wt);
    check_int("flush_gap_4w", wt, 1);
    send_word(mkw($urandom(), rmid()), 1'b0, wt);
    send_word(mkw($urandom(), rmid()), 1'b1, wt);

    // Backpressure mid-packet: 5 cycles of i_block_ready low
    send_word(mkw($urandom(), rmid()), 1'b0, wt);
    check_int("flush_gap_3w", wt, 1);
    send_word(mkw($urandom(), rmid()), 1'b0, wt);
    send_word(mkw($urandom(), rmid()), 1'b0, wt);
    i_block_ready = 1'b0;
    fork
      send_word(mkw($urandom(), rmid()), 1'b0, wt_bp);
      begin
        repeat (5) @(posedge clk);
        #1; i_block_ready = 1'b1;
      end
    join
    check_int("backpressure_stall", wt_bp, 5);
    send_word(mkw($urandom(), rmid()), 1'b1, wt);

    // Reset mid-packet with a block pending
    send_word(mkw($urandom(), rmid()), 1'b0, wt);
    check_int("flush_gap_5w", wt, 1);
    send_word(mkw($urandom(), rmid()), 1'b0, wt);
    i_block_ready = 1'b0;
    send_word(mkw($urandom(), rmid()), 1'b0, wt);
    rst_n = 1'b0;
    @(posedge clk); #1;
    q_blk.delete(); q_hdr.delete(); pkt_idx = 0; m_res = '0;
    @(negedge clk);
    n_asserts++;
    assert ({o_hdr, o_hdr_valid, o_block, o_block_valid, o_block_last, o_block_bytes} === '0) else begin
      n_fail++;
      $error("FAIL midrst_outputs obs=%h/%b/%h/%b/%b/%0d exp=0", o_hdr, o_hdr_valid,
             o_block, o_block_valid, o_block_last, o_block_bytes);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; i_block_ready = 1'b1;

    // Fresh 2-word packet after reset
    send_word(mkw($urandom(), rmid()), 1'b0, wt);
    check_int("post_rst_first_accept", wt, 0);
    send_word(mkw(16'hC0DE, rmid()), 1'b1, wt);

    for (int i = 0; i < 40 && (q_blk.size() != 0 || q_hdr.size() != 0); i++) @(posedge clk);
    @(negedge clk);
    check_int("hdr_queue_drained", q_hdr.size(), 0);
    check_int("blk_queue_drained", q_blk.size(), 0);
    check_int("idle_blk_valid", int'(o_block_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
